vote_button_conditioner: RTL and testbench

Input-conditioning stage placed directly upstream of `voting_machine`: it takes the raw, asynchronous mode switch and four candidate push-buttons from the board and delivers clean, synchronous signals to the counter. Each button is synchronized and debounced. Presses are then qualified so that a hold produces exactly one single-cycle, one-hot vote pulse, and simultaneous presses are rejected and flagged. `voting_machine` consumes `button_pulse[3:0]` on its `button1..button4` inputs and `mode` on its `mode` input.

---
 rtl/voting_pkg.sv | 13 +
 rtl/vote_button_conditioner_if.sv | 24 ++
 rtl/debounce_cell.sv | 36 +++
 rtl/vote_button_conditioner.sv | 106 ++++++++++
 tb/tb_vote_button_conditioner.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/voting_pkg.sv
// Shared types and constants for the voting_machine datapath and its input conditioner.
// No logic; FSM encoding and candidate count only.
package voting_pkg;

   localparam int N_CANDIDATES = 4;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      SETTLE       = 2'd1,
      WAIT_RELEASE = 2'd2
   } vc_state_t;

endpackage

// File: rtl/vote_button_conditioner_if.sv
// Board-side raw inputs and conditioned outputs of vote_button_conditioner.
// slave = the conditioner, master = whoever drives the raw switch/buttons.
interface vote_button_conditioner_if
   import voting_pkg::*;
#(
   parameter int N_BUTTONS = N_CANDIDATES
) ();
   logic                 mode_in;
   logic [N_BUTTONS-1:0] button_in;
   logic                 mode;
   logic [N_BUTTONS-1:0] button_pulse;
   logic                 multi_press;
   logic                 busy;

   modport master (
      output mode_in, button_in,
      input  mode, button_pulse, multi_press, busy
   );

   modport slave (
      input  mode_in, button_in,
      output mode, button_pulse, multi_press, busy
   );
endinterface

// File: rtl/debounce_cell.sv
// One-bit 2-flop synchronizer plus debouncer; level changes after DEBOUNCE_CYCLES
// consecutive cycles of disagreement, 2 + DEBOUNCE_CYCLES cycles from the raw edge.
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         // Any agreeing cycle restarts the count, so short glitches never land.
         if (sync[1] != level) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync[1];
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/vote_button_conditioner.sv
// Conditions raw mode switch and candidate buttons into one-hot single-cycle votes for voting_machine.
// Vote appears 2 + DEBOUNCE_CYCLES + WINDOW_CYCLES cycles after the raw press; presses during WAIT_RELEASE are dropped.
module vote_button_conditioner
   import voting_pkg::*;
#(
   parameter int N_BUTTONS       = N_CANDIDATES,
   parameter int DEBOUNCE_CYCLES = 10,
   parameter int WINDOW_CYCLES   = 4
) (
   input logic                       clk,
   input logic                       rst,
   vote_button_conditioner_if.slave  bus
);
   localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);

   logic [N_BUTTONS-1:0] deb;
   logic [1:0]           mode_sync;
   logic                 mode_prev;

   vc_state_t            state, state_n;
   logic [WIN_W-1:0]     win_cnt, win_n;
   logic [N_BUTTONS-1:0] snapshot, snap_n, snap_all;
   logic [N_BUTTONS-1:0] pulse_q, pulse_n;
   logic                 multi_q, multi_n;
   logic                 busy_q;
   logic                 mode_chg;
   logic                 snap_multi;

   for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (bus.button_in[i]),
         .level (deb[i])
      );
   end

   assign mode_chg   = mode_sync[1] != mode_prev;
   assign snap_all   = snapshot | deb;
   // More than one bit set <=> clearing the lowest set bit leaves something behind.
   assign snap_multi = (snap_all & (snap_all - N_BUTTONS'(1))) != '0;

   always_comb begin
      state_n = state;
      win_n   = win_cnt;
      snap_n  = snapshot;
      pulse_n = '0;
      multi_n = 1'b0;
      case (state)
         IDLE: begin
            if (deb != '0) begin
               state_n = SETTLE;
               win_n   = WIN_W'(WINDOW_CYCLES - 1);
               snap_n  = deb;
            end
         end
         SETTLE: begin
            snap_n = snap_all;
            if (mode_chg) begin
               state_n = WAIT_RELEASE;
            end else if (win_cnt == '0) begin
               state_n = WAIT_RELEASE;
               if (!mode_sync[1]) begin
                  if (snap_multi) multi_n = 1'b1;
                  else            pulse_n = snap_all;
               end
            end else begin
               win_n = win_cnt - WIN_W'(1);
            end
         end
         WAIT_RELEASE: begin
            if (deb == '0) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         win_cnt   <= '0;
         snapshot  <= '0;
         pulse_q   <= '0;
         multi_q   <= 1'b0;
         busy_q    <= 1'b0;
         mode_sync <= '0;
         mode_prev <= 1'b0;
      end else begin
         state     <= state_n;
         win_cnt   <= win_n;
         snapshot  <= snap_n;
         pulse_q   <= pulse_n;
         multi_q   <= multi_n;
         busy_q    <= state_n != IDLE;
         mode_sync <= {mode_sync[0], bus.mode_in};
         mode_prev <= mode_sync[1];
      end
   end

   assign bus.mode         = mode_sync[1];
   assign bus.button_pulse = pulse_q;
   assign bus.multi_press  = multi_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_vote_button_conditioner.sv
// Randomized and directed bench for vote_button_conditioner against a press-session reference model.
module tb_vote_button_conditioner;
   localparam int NB = 4;
   localparam int DB = 4;
   localparam int WN = 2;
   localparam int HN = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          raw_mode;
   logic [NB-1:0] raw_btn;

   always #5 clk = ~clk;

   vote_button_conditioner_if #(.N_BUTTONS(NB)) bus ();
   assign bus.mode_in   = raw_mode;
   assign bus.button_in = raw_btn;

   vote_button_conditioner #(
      .N_BUTTONS       (NB),
      .DEBOUNCE_CYCLES (DB),
      .WINDOW_CYCLES   (WN)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: histories of sampled/synchronized/debounced values plus a press session.
   logic [NB-1:0] samp_h [HN];
   logic [NB-1:0] sync_h [HN];
   logic [NB-1:0] deb_h  [HN];
   logic          msamp_h[HN];
   logic          mode_h [HN];
   int            k;
   bit            in_sess, decided;
   int            start;
   logic [NB-1:0] exp_pulse;
   logic          exp_multi, exp_busy, exp_mode;

   int            npulse, nmulti, last_pulse_k;
   logic [NB-1:0] last_pulse_val;

   function automatic int ix(input int c);
      return c & (HN - 1);
   endfunction

   task automatic model_edge();
      logic [NB-1:0] dp, snap;
      bit            flip;
      exp_pulse = '0;
      exp_multi = 1'b0;
      if (!rst) begin
         samp_h[ix(k)] = '0; sync_h[ix(k)] = '0; deb_h[ix(k)] = '0;
         msamp_h[ix(k)] = 1'b0; mode_h[ix(k)] = 1'b0;
         in_sess = 0;
      end else begin
         samp_h[ix(k)]  = raw_btn;
         sync_h[ix(k)]  = samp_h[ix(k-1)];
         msamp_h[ix(k)] = raw_mode;
         mode_h[ix(k)]  = msamp_h[ix(k-1)];
         // Debounced level flips once the synchronized value disagreed for DB cycles in a row.
         for (int b = 0; b < NB; b++) begin
            flip = 1;
            for (int j = 1; j <= DB; j++)
               if (sync_h[ix(k-j)][b] == deb_h[ix(k-1)][b]) flip = 0;
            deb_h[ix(k)][b] = flip ? ~deb_h[ix(k-1)][b] : deb_h[ix(k-1)][b];
         end
         dp = deb_h[ix(k-1)];
         if (!in_sess) begin
            if (dp != '0) begin
               in_sess = 1; decided = 0; start = k;
            end
         end else if (!decided) begin
            if (mode_h[ix(k-1)] != mode_h[ix(k-2)]) begin
               decided = 1;
            end else if (k == start + WN) begin
               decided = 1;
               snap = '0;
               for (int c = start - 1; c <= k - 1; c++) snap |= deb_h[ix(c)];
               if (mode_h[ix(k-1)] == 1'b0) begin
                  if ($countones(snap) == 1)     exp_pulse = snap;
                  else if ($countones(snap) > 1) exp_multi = 1'b1;
               end
            end
         end else if (dp == '0) begin
            in_sess = 0;
         end
      end
      exp_busy = in_sess;
      exp_mode = mode_h[ix(k)];
   endtask

   task automatic step();
      @(posedge clk);
      k++;
      model_edge();
      #1;
      chk("mode",  bus.mode,         exp_mode);
      chk("pulse", bus.button_pulse, exp_pulse);
      chk("multi", bus.multi_press,  exp_multi);
      chk("busy",  bus.busy,         exp_busy);
      if (bus.button_pulse != '0) begin
         npulse++; last_pulse_k = k; last_pulse_val = bus.button_pulse;
      end
      if (bus.multi_press) nmulti++;
   endtask

   task automatic clr();
      npulse = 0; nmulti = 0; last_pulse_k = -1; last_pulse_val = '0;
   endtask

   int e0, idle_k, mk;

   initial begin
      raw_btn = '0; raw_mode = 1'b0; rst = 1'b0; k = 8;
      for (int i = 0; i < HN; i++) begin
         samp_h[i] = '0; sync_h[i] = '0; deb_h[i] = '0; msamp_h[i] = 0; mode_h[i] = 0;
      end
      in_sess = 0; decided = 0; start = 0;
      clr();

      // Reset held while buttons toggle.
      repeat (12) begin raw_btn = NB'($urandom); raw_mode = 1'($urandom); step(); end
      chk("rst_busy", bus.busy, 0);
      raw_btn = '0; raw_mode = 1'b0; rst = 1'b1; clr();
      repeat (20) step();
      chk("rst_nopulse", npulse, 0);

      // Clean press and release latency.
      clr(); raw_btn = 4'b0001; e0 = k + 1;
      repeat (20) step();
      chk("clean_cnt", npulse, 1);
      chk("clean_val", last_pulse_val, 4'b0001);
      chk("clean_lat", last_pulse_k - e0, 2 + DB + WN);
      raw_btn = '0; e1_blk: begin
         e0 = k + 1; idle_k = -1;
         repeat (12) begin step(); if (idle_k < 0 && !bus.busy) idle_k = k; end
         chk("release_lat", idle_k - e0, DB + 2);
      end

      // Bounce on button 2, then held.
      clr();
      for (int s = 0; s < 6; s++) begin
         raw_btn = (s % 2 == 0) ? 4'b0010 : 4'b0000;
         repeat (2) step();
      end
      raw_btn = 4'b0010; e0 = k + 1;
      repeat (20) step();
      chk("bounce_cnt", npulse, 1);
      chk("bounce_val", last_pulse_val, 4'b0010);
      chk("bounce_lat", last_pulse_k - e0, 2 + DB + WN);
      raw_btn = '0; repeat (15) step();

      // Simultaneous presses, same edge and one-cycle lag.
      clr(); raw_btn = 4'b0110; repeat (20) step();
      chk("simul_multi", nmulti, 1);
      chk("simul_nopulse", npulse, 0);
      raw_btn = '0; repeat (15) step();
      clr(); raw_btn = 4'b0010; step(); raw_btn = 4'b0110; repeat (20) step();
      chk("lag_multi", nmulti, 1);
      chk("lag_nopulse", npulse, 0);
      raw_btn = '0; repeat (15) step();

      // Late second press is ignored.
      clr(); raw_btn = 4'b0001; repeat (10) step();
      raw_btn = 4'b1001; repeat (20) step();
      raw_btn = 4'b1000; repeat (15) step();
      chk("late_cnt", npulse, 1);
      chk("late_val", last_pulse_val, 4'b0001);
      chk("late_multi", nmulti, 0);
      raw_btn = '0; repeat (15) step();

      // Display mode suppresses votes.
      clr(); raw_mode = 1'b1; raw_btn = 4'b0010; e0 = k + 1; mk = -1;
      repeat (20) begin step(); if (mk < 0 && bus.mode) mk = k; end
      chk("mode_lat", mk - e0, 1);
      chk("mode_nopulse", npulse + nmulti, 0);
      raw_btn = '0; repeat (15) step();
      raw_mode = 1'b0; repeat (5) step();

      // Mode glitch inside the window aborts.
      clr(); raw_btn = 4'b0100;
      repeat (DB + 1) step();
      raw_mode = 1'b1; step(); raw_mode = 1'b0;
      repeat (20) step();
      chk("mode_abort", npulse + nmulti, 0);
      raw_btn = '0; repeat (15) step();

      // Reset mid-window.
      clr(); raw_btn = 4'b0001;
      repeat (DB + 3) step();
      chk("settle_busy", bus.busy, 1);
      rst = 1'b0; raw_btn = '0; repeat (2) step();
      rst = 1'b1; repeat (20) step();
      chk("rst_settle", npulse + nmulti, 0);

      // Random segments.
      for (int seg = 0; seg < 150; seg++) begin
         int r, hold;
         r    = $urandom_range(0, 9);
         hold = $urandom_range(1, 20);
         if ($urandom_range(0, 9) == 0) raw_mode = ~raw_mode;
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b0; repeat ($urandom_range(1, 3)) step(); rst = 1'b1;
         end
         case (r)
            0, 1, 2, 3, 4: raw_btn = NB'(1) << $urandom_range(0, NB - 1);
            5, 6:          raw_btn = (NB'(1) << $urandom_range(0, NB - 1)) | (NB'(1) << $urandom_range(0, NB - 1));
            7:             raw_btn = '0;
            default:       raw_btn = NB'($urandom);
         endcase
         for (int c = 0; c < hold; c++) begin
            if (r == 9) raw_btn = NB'($urandom);
            step();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
